// File: rtl/wb_arbiter_if.sv
// Single Wishbone-style bus segment. One instance per master link and one for
// the shared slave link. The slave link's err wire is left unused by the arbiter.
interface wb_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] wdata;
  logic [3:0]  sel;
  logic [15:0] rdata;
  logic        akn;
  logic        err;

  // Initiator view: drives the request, receives data/ack.
  modport master (
    output cyc, stb, we, adr, wdata, sel,
    input  rdata, akn
  );

  // Target view: receives the request, returns data/ack/err.
  modport slave (
    input  cyc, stb, we, adr, wdata, sel,
    output rdata, akn, err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie break, bus lock
// while the granted master holds cyc, and a stall watchdog that aborts with err.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  m0,
  wb_arbiter_if.slave  m1,
  wb_arbiter_if.master s
);

  typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

  localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] wdog_q, wdog_d;

  logic req0, req1;
  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  // Granted-master view, selected by the current busy state.
  logic        g_cyc, g_stb, g_we;
  logic [15:0] g_adr, g_wdata;
  logic [3:0]  g_sel;
  logic        g_err;

  // State, arbitration history and watchdog registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
    end
  end

  // Next-state, watchdog and bus routing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wdog_d       = '0;
    g_err        = 1'b0;

    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.wdata = '0;
    s.sel   = '0;
    m0.rdata = '0;
    m0.akn   = 1'b0;
    m0.err   = 1'b0;
    m1.rdata = '0;
    m1.akn   = 1'b0;
    m1.err   = 1'b0;

    if (state_q == StBusy1) begin
      g_cyc   = m1.cyc;
      g_stb   = m1.stb;
      g_we    = m1.we;
      g_adr   = m1.adr;
      g_wdata = m1.wdata;
      g_sel   = m1.sel;
    end else begin
      g_cyc   = m0.cyc;
      g_stb   = m0.stb;
      g_we    = m0.we;
      g_adr   = m0.adr;
      g_wdata = m0.wdata;
      g_sel   = m0.sel;
    end

    unique case (state_q)
      StIdle: begin
        // m0 wins when alone or when m1 had the previous grant.
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = StBusy0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = StBusy1;
          last_grant_d = 1'b1;
        end
      end
      StBusy0, StBusy1: begin
        s.cyc   = g_cyc;
        s.stb   = g_stb;
        s.we    = g_we;
        s.adr   = g_adr;
        s.wdata = g_wdata;
        s.sel   = g_sel;

        // Ack beats the timeout on the same cycle.
        if (s.akn || !g_stb) begin
          wdog_d = '0;
        end else if (wdog_q == WdogLast) begin
          g_err   = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end

        if (!g_cyc) begin
          state_d = StIdle;
        end

        if (state_q == StBusy1) begin
          m1.rdata = s.rdata;
          m1.akn   = s.akn;
          m1.err   = g_err;
        end else begin
          m0.rdata = s.rdata;
          m0.akn   = s.akn;
          m0.err   = g_err;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter built with a 4-cycle watchdog.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_arbiter_if m0_bus ();
  wb_arbiter_if m1_bus ();
  wb_arbiter_if s_bus ();

  wb_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s"}, {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdata, s_bus.sel},
             64'h0);
    check_eq({tag, "_m0"}, {m0_bus.akn, m0_bus.err, m0_bus.rdata}, 64'h0);
    check_eq({tag, "_m1"}, {m1_bus.akn, m1_bus.err, m1_bus.rdata}, 64'h0);
  endtask

  task automatic m0_set(input logic cyc, input logic stb, input logic we,
                        input logic [15:0] adr);
    m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr;
    m0_bus.wdata = 16'h0; m0_bus.sel = 4'hF;
  endtask

  task automatic m1_set(input logic cyc, input logic stb, input logic we,
                        input logic [15:0] adr, input logic [15:0] wdata);
    m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr;
    m1_bus.wdata = wdata; m1_bus.sel = 4'h3;
  endtask

  logic [15:0] beats [3];

  initial begin
    beats[0] = 16'h1111;
    beats[1] = 16'h2222;
    beats[2] = 16'h3333;

    rst = 1'b0;
    m0_set(0, 0, 0, 16'h0);
    m1_set(0, 0, 0, 16'h0, 16'h0);
    s_bus.akn = 1'b0; s_bus.rdata = 16'h0; s_bus.err = 1'b0;

    // Reset state
    tick(); tick(); #1;
    check_all_zero("reset");

    // Tie after reset goes to m0, then m1, then m0 again
    rst = 1'b1;
    m0_set(1, 1, 0, 16'hA000);
    m1_set(1, 1, 1, 16'hB000, 16'h5555);
    #1 check_eq("tie_idle_cyc", s_bus.cyc, 1'b0);
    tick();
    s_bus.akn = 1'b1; s_bus.rdata = 16'h1234;
    #1;
    check_eq("tie_grant_m0", s_bus.adr, 16'hA000);
    check_eq("tie_m0_akn", m0_bus.akn, 1'b1);
    check_eq("tie_m1_quiet", {m1_bus.akn, m1_bus.err, m1_bus.rdata}, 64'h0);
    tick();
    m0_set(0, 0, 0, 16'hA000); s_bus.akn = 1'b0;
    tick(); #1;
    check_eq("tie_gap_idle", s_bus.cyc, 1'b0);
    tick(); #1;
    check_eq("tie_grant_m1", {s_bus.adr, s_bus.wdata, s_bus.sel, s_bus.we},
             {16'hB000, 16'h5555, 4'h3, 1'b1});
    tick();
    m1_set(0, 0, 0, 16'hB000, 16'h0);
    m0_set(1, 1, 0, 16'hA000);
    tick();
    m1_set(1, 1, 1, 16'hB000, 16'h5555);
    #1 check_eq("tie2_idle", s_bus.cyc, 1'b0);
    tick(); #1;
    check_eq("tie2_grant_m0", s_bus.adr, 16'hA000);
    tick();
    m0_set(0, 0, 0, 16'h0);
    m1_set(0, 0, 0, 16'h0, 16'h0);
    tick(); tick();

    // Single read from m0, ack two cycles after strobe
    m0_set(1, 1, 0, 16'h0010);
    #1 check_eq("rd_latency", s_bus.cyc, 1'b0);
    tick(); #1;
    check_eq("rd_adr", {s_bus.adr, s_bus.stb, m0_bus.akn}, {16'h0010, 1'b1, 1'b0});
    tick(); #1;
    check_eq("rd_wait", m0_bus.akn, 1'b0);
    tick();
    s_bus.akn = 1'b1; s_bus.rdata = 16'hBEEF;
    #1;
    check_eq("rd_data", {m0_bus.akn, m0_bus.rdata}, {1'b1, 16'hBEEF});
    check_eq("rd_m1_quiet", {m1_bus.akn, m1_bus.err, m1_bus.rdata}, 64'h0);
    tick();
    m0_set(0, 0, 0, 16'h0); s_bus.akn = 1'b0;
    tick();
    s_bus.akn = 1'b1;
    #1 check_eq("idle_ign_akn", {m0_bus.akn, m0_bus.rdata, m1_bus.akn}, 64'h0);
    s_bus.akn = 1'b0;

    // m1 three-beat locked write while m0 waits
    tick();
    m1_set(1, 1, 1, 16'h0200, beats[0]);
    #1 check_eq("wr_latency", s_bus.cyc, 1'b0);
    tick();
    m0_set(1, 1, 0, 16'hA000);
    s_bus.akn = 1'b1;
    #1;
    check_eq("wr_beat0", {s_bus.wdata, s_bus.we, m1_bus.akn, m0_bus.akn},
             {beats[0], 1'b1, 1'b1, 1'b0});
    for (int i = 1; i < 3; i++) begin
      tick();
      m1_bus.stb = 1'b0; s_bus.akn = 1'b0;
      #1 check_eq($sformatf("wr_gap%0d", i), {s_bus.cyc, s_bus.adr}, {1'b1, 16'h0200});
      tick();
      m1_bus.stb = 1'b1; m1_bus.wdata = beats[i]; s_bus.akn = 1'b1;
      #1 check_eq($sformatf("wr_beat%0d", i), {s_bus.wdata, m1_bus.akn, m0_bus.akn},
                  {beats[i], 1'b1, 1'b0});
    end
    tick();
    m1_set(0, 0, 0, 16'h0200, 16'h0); s_bus.akn = 1'b0;
    #1 check_eq("wr_release", s_bus.adr, 16'h0200);
    tick(); #1;
    check_eq("wr_idle", s_bus.cyc, 1'b0);
    tick(); #1;
    check_eq("wr_m0_grant", s_bus.adr, 16'hA000);
    tick();
    m0_set(0, 0, 0, 16'h0);
    tick();

    // Watchdog abort on the 4th stalled cycle
    m0_set(1, 1, 0, 16'h0300);
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      check_eq($sformatf("wd_stall%0d_err", i), m0_bus.err, (i == 4) ? 1'b1 : 1'b0);
    end
    check_eq("wd_err_others", {m0_bus.akn, m1_bus.err, s_bus.cyc}, {1'b0, 1'b0, 1'b1});
    tick();
    m0_bus.stb = 1'b0;
    #1 check_eq("wd_idle", {s_bus.cyc, m0_bus.err}, 64'h0);
    tick(); #1;
    check_eq("cyc_no_stb", s_bus.cyc, 1'b0);
    m0_bus.stb = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) s_bus.akn = 1'b1;
      #1;
    end
    check_eq("wd_ack_wins", {m0_bus.akn, m0_bus.err}, {1'b1, 1'b0});
    tick();
    s_bus.akn = 1'b0; m0_bus.stb = 1'b0;
    #1 check_eq("wd_after_ack", {s_bus.cyc, m0_bus.err}, {1'b1, 1'b0});
    tick();
    m0_set(0, 0, 0, 16'h0);
    tick();

    // Reset in the middle of a BUSY1 transfer
    m1_set(1, 1, 0, 16'hB000, 16'h0);
    tick(); #1;
    check_eq("rst_busy1", s_bus.adr, 16'hB000);
    rst = 1'b0;
    m0_set(1, 1, 0, 16'hA000);
    tick(); #1;
    check_all_zero("rst_drop");
    s_bus.akn = 1'b1; s_bus.rdata = 16'hFFFF;
    #1 check_eq("rst_akn", {m1_bus.akn, m1_bus.rdata, m0_bus.akn}, 64'h0);
    tick(); #1;
    check_all_zero("rst_held");
    rst = 1'b1; s_bus.akn = 1'b0;
    tick(); #1;
    check_eq("rst_tie_m0", s_bus.adr, 16'hA000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
